// File: rtl/aes_ise_pkg.sv
// AES instruction-set-extension shared definitions.
// FSM encoding and GF(2^8) constant for the MixColumns ISE family.
package aes_ise_pkg;

  typedef logic [7:0] byte_t;

  typedef struct packed {
    byte_t c0;
    byte_t c1;
    byte_t c2;
    byte_t c3;
  } col_t;

  localparam byte_t GF_RED = 8'h1b;

  localparam logic [2:0] LOAD_01 = 3'd0;
  localparam logic [2:0] LOAD_23 = 3'd1;
  localparam logic [2:0] PRE     = 3'd2;
  localparam logic [2:0] MIX     = 3'd3;
  localparam logic [2:0] OUT2    = 3'd4;
  localparam logic [2:0] OUT1    = 3'd5;
  localparam logic [2:0] OUT0    = 3'd6;

endpackage

// File: rtl/aimc_ise_if.sv
// Core-side bus of the InvMixColumns ISE.
// master = issuing core, slave = ISE unit.
interface aimc_ise_if;

  logic       start;
  logic [7:0] a;
  logic [7:0] b;
  logic [7:0] sr;
  logic [7:0] sr_out;
  logic [7:0] result;
  logic       wait_req;

  modport master (
    output start, a, b, sr,
    input  sr_out, result, wait_req
  );

  modport slave (
    input  start, a, b, sr,
    output sr_out, result, wait_req
  );

endinterface

// File: rtl/aes_xtime.sv
// GF(2^8) multiply-by-x with the AES reduction polynomial.
// Pure combinational helper.
module aes_xtime
  import aes_ise_pkg::*;
(
  input  byte_t x,
  output byte_t y
);

  assign y = {x[6:0], 1'b0} ^ (x[7] ? GF_RED : 8'h00);

endmodule

// File: rtl/aimc_ise.sv
// AES InvMixColumns ISE: one column over five core calls.
// Inverse is done as a pre-multiply step followed by forward MixColumns.
module aimc_ise
  import aes_ise_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic [7:0] a,
  input  logic [7:0] b,
  input  logic [7:0] sr,
  output logic [7:0] sr_out,
  output logic [7:0] result,
  output logic       wait_req
);

  logic [2:0] state;
  logic [2:0] state_nxt;
  col_t       s;
  col_t       o;
  col_t       mix;
  byte_t      u1, u;
  byte_t      v1, v;
  byte_t      t;
  byte_t      x0, x1, x2, x3;

  assign sr_out = sr;

  aes_xtime u_xu1 (.x(s.c0 ^ s.c2), .y(u1));
  aes_xtime u_xu2 (.x(u1),          .y(u));
  aes_xtime u_xv1 (.x(s.c1 ^ s.c3), .y(v1));
  aes_xtime u_xv2 (.x(v1),          .y(v));

  assign t = s.c0 ^ s.c1 ^ s.c2 ^ s.c3;

  aes_xtime u_xm0 (.x(s.c0 ^ s.c1), .y(x0));
  aes_xtime u_xm1 (.x(s.c1 ^ s.c2), .y(x1));
  aes_xtime u_xm2 (.x(s.c2 ^ s.c3), .y(x2));
  aes_xtime u_xm3 (.x(s.c3 ^ s.c0), .y(x3));

  assign mix = {
    s.c0 ^ t ^ x0,
    s.c1 ^ t ^ x1,
    s.c2 ^ t ^ x2,
    s.c3 ^ t ^ x3
  };

  always_comb begin
    state_nxt = state;
    wait_req  = 1'b0;
    case (state)
      LOAD_01: if (start) state_nxt = LOAD_23;
      LOAD_23: begin
        if (start) begin
          state_nxt = PRE;
          wait_req  = 1'b1;
        end
      end
      PRE: begin
        state_nxt = MIX;
        wait_req  = 1'b1;
      end
      MIX: begin
        state_nxt = OUT2;
        wait_req  = 1'b1;
      end
      OUT2:    if (start) state_nxt = OUT1;
      OUT1:    if (start) state_nxt = OUT0;
      OUT0:    if (start) state_nxt = LOAD_01;
      default: state_nxt = LOAD_01;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= LOAD_01;
      s      <= '0;
      o      <= '0;
      result <= '0;
    end else begin
      state  <= state_nxt;
      result <= '0;
      case (state)
        LOAD_01: begin
          if (start) begin
            s.c0 <= a;
            s.c1 <= b;
          end
        end
        LOAD_23: begin
          if (start) begin
            s.c2 <= a;
            s.c3 <= b;
          end
        end
        PRE: begin
          s <= {s.c0 ^ u, s.c1 ^ v, s.c2 ^ u, s.c3 ^ v};
        end
        MIX: begin
          o      <= mix;
          result <= mix.c3;
        end
        OUT2, OUT1, OUT0: begin
          // rotate so the next byte to return always sits in c2
          if (start) begin
            result <= o.c2;
            o      <= {o.c3, o.c0, o.c1, o.c2};
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_aimc_ise.sv
// Self-checking bench for aimc_ise.
// Table vectors plus a GF(2^8) reference model feeding a scoreboard.
module tb_aimc_ise;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;

  aimc_ise_if bus ();

  aimc_ise dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (bus.start),
    .a        (bus.a),
    .b        (bus.b),
    .sr       (bus.sr),
    .sr_out   (bus.sr_out),
    .result   (bus.result),
    .wait_req (bus.wait_req)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] col;
    logic [31:0] exp;
    int          gap;
    bit          poke;
  } vec_t;

  vec_t       vt[5];
  int         n_chk  = 0;
  int         n_fail = 0;
  logic [7:0] q[$];
  bit         pend   = 1'b0;

  function automatic logic [7:0] gmul(logic [7:0] x, logic [7:0] y);
    logic [7:0] p = 8'h00;
    for (int i = 0; i < 8; i++) begin
      if (y[i]) p ^= x;
      x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
    end
    return p;
  endfunction

  // returns {s3', s2', s1', s0'}
  function automatic logic [31:0] inv_mix(logic [31:0] c);
    logic [7:0] s0, s1, s2, s3, r0, r1, r2, r3;
    s0 = c[31:24];
    s1 = c[23:16];
    s2 = c[15:8];
    s3 = c[7:0];
    r0 = gmul(s0, 8'd14) ^ gmul(s1, 8'd11) ^ gmul(s2, 8'd13) ^ gmul(s3, 8'd9);
    r1 = gmul(s0, 8'd9) ^ gmul(s1, 8'd14) ^ gmul(s2, 8'd11) ^ gmul(s3, 8'd13);
    r2 = gmul(s0, 8'd13) ^ gmul(s1, 8'd9) ^ gmul(s2, 8'd14) ^ gmul(s3, 8'd11);
    r3 = gmul(s0, 8'd11) ^ gmul(s1, 8'd13) ^ gmul(s2, 8'd9) ^ gmul(s3, 8'd14);
    return {r3, r2, r1, r0};
  endfunction

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic push_exp(input logic [31:0] e);
    q.push_back(e[31:24]);
    q.push_back(e[23:16]);
    q.push_back(e[15:8]);
    q.push_back(e[7:0]);
  endtask

  // one clock cycle, entered and left at posedge+1
  task automatic cyc(input bit st, input logic [7:0] ia, input logic [7:0] ib,
                     input bit ld, input bit wexp);
    logic [7:0] e;
    bus.start = st;
    bus.a     = ia;
    bus.b     = ib;
    bus.sr    = 8'($urandom);
    e         = 8'h00;
    @(negedge clk);
    if (pend) begin
      if (q.size() == 0) begin
        n_chk++;
        n_fail++;
        $display("FAIL scoreboard_empty: got none expected entry");
      end else begin
        e = q.pop_front();
      end
    end
    chk("result", {24'h0, bus.result}, {24'h0, e});
    chk("wait_req", {31'h0, bus.wait_req}, {31'h0, wexp});
    chk("sr_out", {24'h0, bus.sr_out}, {24'h0, bus.sr});
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    pend      = ld;
  endtask

  task automatic idle();
    cyc(1'b0, 8'($urandom), 8'($urandom), 1'b0, 1'b0);
  endtask

  task automatic col_front(input logic [31:0] c, input int gap, input bit poke);
    repeat (gap) idle();
    cyc(1'b1, c[31:24], c[23:16], 1'b0, 1'b0);
    repeat (gap) idle();
    cyc(1'b1, c[15:8], c[7:0], 1'b0, 1'b1);
    cyc(poke, 8'($urandom), 8'($urandom), 1'b0, 1'b1);
    cyc(1'b0, 8'($urandom), 8'($urandom), 1'b1, 1'b1);
  endtask

  task automatic out_call(input int gap);
    repeat (gap) idle();
    cyc(1'b1, 8'($urandom), 8'($urandom), 1'b1, 1'b0);
  endtask

  task automatic run_col(input logic [31:0] c, input int gap, input bit poke);
    col_front(c, gap, poke);
    repeat (3) out_call(gap);
  endtask

  task automatic mid_reset(input logic [7:0] e_res, input bit e_wait);
    chk("pre_rst_result", {24'h0, bus.result}, {24'h0, e_res});
    chk("pre_rst_wait", {31'h0, bus.wait_req}, {31'h0, e_wait});
    #2 rst_n = 1'b0;
    #1;
    chk("rst_result", {24'h0, bus.result}, 32'h0);
    chk("rst_wait", {31'h0, bus.wait_req}, 32'h0);
    q.delete();
    pend = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [31:0] c;
    bus.start = 1'b0;
    bus.a     = 8'h00;
    bus.b     = 8'h00;
    bus.sr    = 8'ha5;

    vt[0] = '{col: 32'h8e4da1bc, exp: 32'h455313db, gap: 0, poke: 1'b0};
    vt[1] = '{col: 32'h9fdc589d, exp: 32'h5c220af2, gap: 0, poke: 1'b0};
    vt[2] = '{col: 32'h01010101, exp: 32'h01010101, gap: 0, poke: 1'b0};
    vt[3] = '{col: 32'hd5d5d7d6, exp: 32'hd5d4d4d4, gap: 0, poke: 1'b0};
    vt[4] = '{col: 32'h8e4da1bc, exp: 32'h455313db, gap: 5, poke: 1'b1};

    repeat (2) @(posedge clk);
    #1;
    chk("reset_result", {24'h0, bus.result}, 32'h0);
    chk("reset_wait", {31'h0, bus.wait_req}, 32'h0);
    chk("reset_sr_out", {24'h0, bus.sr_out}, 32'h000000a5);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    for (int i = 0; i < 5; i++) begin
      push_exp(vt[i].exp);
      run_col(vt[i].col, vt[i].gap, vt[i].poke);
    end

    for (int k = 0; k < 4; k++) begin
      c = $urandom;
      push_exp(inv_mix(c));
      run_col(c, $urandom_range(0, 2), 1'($urandom));
    end
    idle();

    // abandon a column in MIX
    push_exp(32'h455313db);
    cyc(1'b1, 8'h8e, 8'h4d, 1'b0, 1'b0);
    cyc(1'b1, 8'ha1, 8'hbc, 1'b0, 1'b1);
    cyc(1'b0, 8'h00, 8'h00, 1'b0, 1'b1);
    mid_reset(8'h00, 1'b1);
    push_exp(32'h455313db);
    run_col(32'h8e4da1bc, 1, 1'b0);
    idle();

    // abandon a column in OUT1 while s2' is on result
    push_exp(32'h455313db);
    col_front(32'h8e4da1bc, 0, 1'b0);
    out_call(0);
    mid_reset(8'h53, 1'b0);
    push_exp(32'h455313db);
    run_col(32'h8e4da1bc, 0, 1'b0);
    idle();
    idle();

    chk("scoreboard_drained", q.size(), 32'h0);
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected end of test");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/aimc_ise.md
AIMC_ISE -- requirements
Module: aimc_ise

Interface
REQ-001 SHALL provide ports: clk  in  1  rising-edge clock.
REQ-002 SHALL provide: rst_n  in  1  reset, asynchronous, active-low.
REQ-003 SHALL provide: start  in  1  ISE call strobe, one cycle per accepted call.
REQ-004 SHALL provide: a  in  8  first operand byte.
REQ-005 SHALL provide: b  in  8  second operand byte.
REQ-006 SHALL provide: sr  in  8  status register in.
REQ-007 SHALL provide: sr_out  out  8  status register out.
REQ-008 SHALL provide: result  out  8  registered result byte.
REQ-009 SHALL provide: wait_req  out  1  core stall request.
REQ-010 SHALL have no parameters; GF(2^8) reduction constant 8'h1b is fixed.

Function
REQ-011 SHALL compute AES InvMixColumns of one column (s0..s3) over five calls: call1 a=s0,b=s1; call2 a=s2,b=s3, returns s3'; call3 returns s2'; call4 returns s1'; call5 returns s0'.
REQ-012 SHALL drive sr_out = sr combinationally; status is never modified.
REQ-013 SHALL implement states LOAD_01, LOAD_23, PRE, MIX, OUT2, OUT1, OUT0.
REQ-014 Transitions SHALL be: LOAD_01 -start-> LOAD_23 -start-> PRE -> MIX -> OUT2 -start-> OUT1 -start-> OUT0 -start-> LOAD_01; without start, LOAD/OUT states hold.
REQ-015 LOAD_01 with start SHALL latch s0=a, s1=b; result 0 next cycle.
REQ-016 LOAD_23 with start SHALL latch s2=a, s3=b and assert wait_req combinationally in that cycle.
REQ-017 wait_req SHALL be 1 throughout PRE and MIX and 0 in every other state; stall = 3 cycles total (start cycle, PRE, MIX).
REQ-018 PRE SHALL compute u=xtime(xtime(s0^s2)), v=xtime(xtime(s1^s3)) and update s0^=u, s1^=v, s2^=u, s3^=v.
REQ-019 MIX SHALL compute forward MixColumns of updated s0..s3 into buffers o0..o3 (oi = si ^ t ^ xtime(si^s(i+1 mod 4)), t = s0^s1^s2^s3) and load result=o3.
REQ-020 In OUT2/OUT1/OUT0, start SHALL load result with o2/o1/o0 respectively at that clock edge.
REQ-021 result SHALL be nonzero-capable for exactly one cycle after each load (cycle after MIX; cycle after start in OUT states) and SHALL be 0 in all other cycles.
REQ-022 xtime(x) SHALL equal {x[6:0],0} ^ (x[7] ? 8'h1b : 0); all arithmetic 8-bit XOR, no carries.
REQ-023 start during PRE or MIX SHALL be ignored (no state or data change).
REQ-024 a/b SHALL be sampled only in the start cycle of LOAD_01/LOAD_23; values in other cycles are ignored.
REQ-025 Back-to-back columns SHALL be supported: start in LOAD_01 the cycle after call5 is accepted.

Reset
REQ-026 rst_n low SHALL asynchronously force state=LOAD_01, result=0, wait_req=0, s0..s3=0, o0..o3=0.
REQ-027 Reset asserted mid-operation (any state, including during stall) SHALL abandon the column; wait_req drops immediately; next call is treated as call1.
REQ-028 No register SHALL rely on initial values for correctness.

Structure
REQ-029 State encoding (3-bit localparams) and constant 8'h1b SHALL live in shared package aes_ise_pkg, shared with the forward MixColumns ISE.
REQ-030 xtime SHALL be a combinational sub-module aes_xtime (8-bit in/out), instantiated as needed (2 chained in PRE per byte pair, 4 in MIX).
REQ-031 Implementation SHALL be a single always_ff with async reset plus one combinational next-state/wait_req block.

Verification
REQ-032 Column 8e,4d,a1,bc -> results in call order bc-row s3'=45, s2'=53, s1'=13, s0'=db.
REQ-033 Column 9f,dc,58,9d -> s3'=5c, s2'=22, s1'=0a, s0'=f2; wait_req high exactly 3 cycles starting at call2 start.
REQ-034 Column 01,01,01,01 -> all results 01; column d5,d5,d7,d6 immediately back-to-back -> d5,d4,d4,d4 (s3'..s0').
REQ-035 Idle gaps of 5 cycles between every call; result 0 during gaps, values as REQ-032; start pulsed during PRE has no effect.
REQ-036 rst_n pulsed low mid-MIX and mid-OUT1 -> wait_req and result 0 asynchronously, following column 8e,4d,a1,bc returns correct values; sr=a5 -> sr_out=a5 always.
